// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared seven-segment constants and width helper
package disp_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Lit-high patterns, bit SEG_A in the LSB
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int idx_width(input int digits);
      return (digits < 2) ? 1 : $clog2(digits);
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to lit-high segment pattern
module hex_to_7seg
   import disp_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - N-digit multiplexed seven-segment scan controller
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int DIGITS           = 8,
   parameter int REFRESH_DIV      = 100000,
   parameter int GUARD_CYCLES     = 4,
   parameter int ANODE_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 1,
   localparam int IDXW            = idx_width(DIGITS)
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [4*DIGITS-1:0]   i_data_in,
   input  logic [DIGITS-1:0]     i_dp_in,
   input  logic [DIGITS-1:0]     i_digit_en,
   input  logic                  i_blank_lz,
   input  logic                  i_load,
   output logic [DIGITS-1:0]     o_anode,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [IDXW-1:0]       o_digit_idx,
   output logic                  o_frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic              DP_OFF    = (SEG_ACTIVE_LOW != 0);

   logic [PW-1:0]       r_presc;
   logic [IDXW-1:0]     r_idx;
   logic [4*DIGITS-1:0] r_pend;
   logic [DIGITS-1:0]   r_pend_dp;
   logic                r_pend_vld;
   logic [4*DIGITS-1:0] r_act;
   logic [DIGITS-1:0]   r_act_dp;
   logic [DIGITS-1:0]   r_anode;
   logic [6:0]          r_seg;
   logic                r_dp;
   logic                r_frame_done;

   logic                w_tick;
   logic                w_wrap;
   logic [3:0]          w_nibble;
   logic [6:0]          w_lit_seg;
   logic                w_upper_zero;
   logic                w_visible;
   logic [DIGITS-1:0]   w_onehot;
   logic [DIGITS-1:0]   w_anode_lit;

   hex_to_7seg u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_lit_seg)
   );

   assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));
   assign w_wrap = w_tick && (r_idx == IDXW'(DIGITS - 1));

   always_comb begin
      w_nibble     = r_act[r_idx*4 +: 4];
      w_upper_zero = 1'b1;
      // Leading zero: this digit and every more-significant nibble are zero
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(r_idx) && r_act[4*j +: 4] != 4'h0) begin
            w_upper_zero = 1'b0;
         end
      end
      w_visible        = i_digit_en[r_idx] && !(i_blank_lz && (r_idx != '0) && w_upper_zero);
      w_onehot         = '0;
      w_onehot[r_idx]  = 1'b1;
      w_anode_lit      = (w_visible && (r_presc >= PW'(GUARD_CYCLES))) ? w_onehot : '0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_pend       <= '0;
         r_pend_dp    <= '0;
         r_pend_vld   <= 1'b0;
         r_act        <= '0;
         r_act_dp     <= '0;
         r_anode      <= ANODE_OFF;
         r_seg        <= SEG_OFF;
         r_dp         <= DP_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         r_frame_done <= w_wrap;
         if (w_tick) begin
            r_idx <= (r_idx == IDXW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end
         // Frame buffer swaps only at the wrap so a frame is never torn
         if (w_wrap) begin
            r_pend_vld <= 1'b0;
            if (i_load) begin
               r_act    <= i_data_in;
               r_act_dp <= i_dp_in;
            end else if (r_pend_vld) begin
               r_act    <= r_pend;
               r_act_dp <= r_pend_dp;
            end
         end else if (i_load) begin
            r_pend     <= i_data_in;
            r_pend_dp  <= i_dp_in;
            r_pend_vld <= 1'b1;
         end
         r_anode <= (ANODE_ACTIVE_LOW != 0) ? ~w_anode_lit : w_anode_lit;
         r_seg   <= (SEG_ACTIVE_LOW != 0) ? ~w_lit_seg : w_lit_seg;
         r_dp    <= (SEG_ACTIVE_LOW != 0) ? ~r_act_dp[r_idx] : r_act_dp[r_idx];
      end
   end

   assign o_anode      = r_anode;
   assign o_seg        = r_seg;
   assign o_dp         = r_dp;
   assign o_digit_idx  = r_idx;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        blank_lz;
   logic        load;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int tests = 0;
   int fails = 0;
   int n     = 0;

   display_scan_ctrl #(
      .DIGITS           (4),
      .REFRESH_DIV      (8),
      .GUARD_CYCLES     (2),
      .ANODE_ACTIVE_LOW (1),
      .SEG_ACTIVE_LOW   (1)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_data_in    (data_in),
      .i_dp_in      (dp_in),
      .i_digit_en   (digit_en),
      .i_blank_lz   (blank_lz),
      .i_load       (load),
      .o_anode      (anode),
      .o_seg        (seg),
      .o_dp         (dp),
      .o_digit_idx  (digit_idx),
      .o_frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // n counts rising edges since reset release; sample 1 time unit after the edge
   task automatic go_to(input int target);
      while (n < target) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      data_in  = 16'h0000;
      dp_in    = 4'h0;
      digit_en = 4'hF;
      blank_lz = 1'b0;
      load     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_anode", anode, 4'b1111);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_fd", frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;

      go_to(2);
      load = 1'b1; data_in = 16'h12AF; dp_in = 4'h0;
      go_to(3);
      load = 1'b0;
      go_to(31); check("fd_before_wrap", frame_done, 1'b0);
      go_to(32); check("fd_wrap1", frame_done, 1'b1);
      go_to(33); check("fd_after_wrap", frame_done, 1'b0);
      go_to(34); check("guard_s0_anode", anode, 4'b1111);
                 check("guard_s0_seg", seg, 7'h0E);
      go_to(36); check("s0_anode", anode, 4'b1110);
                 check("s0_seg_F", seg, 7'h0E);
                 check("s0_dp", dp, 1'b1);

      go_to(41);
      load = 1'b1; data_in = 16'h1111; dp_in = 4'b0100;
      go_to(42);
      load = 1'b0;
      go_to(44); check("s1_seg_A", seg, 7'h08);
                 check("s1_anode", anode, 4'b1101);
                 check("idx_1", digit_idx, 2'd1);
      go_to(52); check("s2_seg_2", seg, 7'h24);
                 check("s2_anode", anode, 4'b1011);
      go_to(60); check("s3_seg_1", seg, 7'h79);
                 check("s3_anode", anode, 4'b0111);
      go_to(63); check("fd_pre2", frame_done, 1'b0);
      go_to(64); check("fd_wrap2", frame_done, 1'b1);
      go_to(65); check("fd_post2", frame_done, 1'b0);
      go_to(68); check("f3_s0_seg", seg, 7'h79);
                 check("f3_s0_dp", dp, 1'b1);

      for (int k = 73; k <= 80; k++) begin
         go_to(k);
         check("guard_s1", anode, (k < 75) ? 4'b1111 : 4'b1101);
      end
      digit_en = 4'b1011;
      for (int k = 81; k <= 88; k++) begin
         go_to(k);
         check("dark_s2", anode, 4'b1111);
      end
      check("f3_s2_dp", dp, 1'b0);
      digit_en = 4'hF;
      go_to(92); check("f3_s3_seg", seg, 7'h79);
                 check("f3_s3_anode", anode, 4'b0111);

      go_to(95);
      load = 1'b1; data_in = 16'h3333; dp_in = 4'h0;
      go_to(96);
      load = 1'b0;
      check("fd_wrap3", frame_done, 1'b1);
      check("bypass_pend_vld", dut.r_pend_vld, 1'b0);
      go_to(99); check("bypass_seg_3", seg, 7'h30);
                 check("bypass_anode", anode, 4'b1110);

      blank_lz = 1'b1;
      load = 1'b1; data_in = 16'h0050;
      go_to(100);
      load = 1'b0;
      go_to(132); check("lz_s0_seg", seg, 7'h40);
                  check("lz_s0_anode", anode, 4'b1110);
      go_to(140); check("lz_s1_seg", seg, 7'h12);
                  check("lz_s1_anode", anode, 4'b1101);
      go_to(148); check("lz_s2_anode", anode, 4'b1111);
      go_to(156); check("lz_s3_anode", anode, 4'b1111);

      go_to(180); check("pre_rst_idx", digit_idx, 2'd2);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_anode", anode, 4'b1111);
      check("mid_rst_seg", seg, 7'h7F);
      check("mid_rst_dp", dp, 1'b1);
      check("mid_rst_idx", digit_idx, 2'd0);
      check("mid_rst_fd", frame_done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      go_to(3);  check("post_rst_anode", anode, 4'b1110);
                 check("post_rst_seg", seg, 7'h40);
      go_to(11); check("post_rst_lz_s1", anode, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
